// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared constants, FSM encoding and helpers for the watchdog config controller
// Contents: default data/address width, watchdog timeout register address,
//           controller state encoding, one-hot requester helper.
package wdt_pkg;

   localparam int unsigned WDT_WIDTH            = 8;
   localparam logic [7:0]  WDT_TIMEOUT_REG_ADDR = 8'hA0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_W_SETUP  = 3'd1,
      ST_W_ACCESS = 3'd2,
      ST_R_SETUP  = 3'd3,
      ST_R_ACCESS = 3'd4,
      ST_DONE     = 3'd5
   } wdt_state_e;

   // Requester index to its one-hot position in the 2-wide pulse vectors.
   function automatic logic [1:0] wdt_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/wdt_cfg_ctrl_if.sv
// rtl/wdt_cfg_ctrl_if.sv - APB bus bundle between the config controller and the watchdog completer
// Signals: psel_o, penable_o, pwrite_o, paddr_o[WIDTH], pwdata_o[WIDTH]  (controller -> completer)
//          pready_i, prdata_i[WIDTH]                                     (completer -> controller)
// Modports: master (controller side), slave (completer side).
interface wdt_cfg_ctrl_if
   import wdt_pkg::*;
#(
   parameter int unsigned WIDTH = WDT_WIDTH
) ();

   logic             psel_o;
   logic             penable_o;
   logic             pwrite_o;
   logic [WIDTH-1:0] paddr_o;
   logic [WIDTH-1:0] pwdata_o;
   logic             pready_i;
   logic [WIDTH-1:0] prdata_i;

   modport master (
      output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
      input  pready_i, prdata_i
   );

   modport slave (
      input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
      output pready_i, prdata_i
   );

endinterface

// File: rtl/wdt_rr_arb2.sv
// rtl/wdt_rr_arb2.sv - two-way round-robin arbiter
// Ports: clk_i, rst_ni (async active-low)
//        req_i[2]    request vector
//        accept_i    the current grant is taken; moves the priority pointer
//        gnt_o[2]    one-hot grant (combinational, zero when nothing requests)
module wdt_rr_arb2
   import wdt_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   // prio_q names the requester that wins a tie; reset favours requester 0.
   logic prio_q;
   logic prio_d;

   always_comb begin
      gnt_o  = 2'b00;
      prio_d = prio_q;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = wdt_onehot(prio_q);
         default: gnt_o = 2'b00;
      endcase
      // Whoever was just served yields the next tie to the other side.
      if (accept_i && (|req_i)) begin
         prio_d = gnt_o[0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/wdt_cfg_ctrl.sv
// rtl/wdt_cfg_ctrl.sv - watchdog timeout programming controller with optional readback verify
// Ports: pclk_i, prst_ni (async active-low)
//        req_i[2], req_data_i[2*WIDTH], req_verify_i[2]  requester side (level requests)
//        gnt_o[2], done_o[2], err_o[2]                  one-cycle one-hot pulses
//        busy_o                                          transaction in flight
//        apb (wdt_cfg_ctrl_if.master)                    APB master to the watchdog
module wdt_cfg_ctrl
   import wdt_pkg::*;
#(
   parameter int unsigned      WIDTH            = WDT_WIDTH,
   parameter logic [WIDTH-1:0] TIMEOUT_REG_ADDR = WIDTH'(WDT_TIMEOUT_REG_ADDR),
   parameter int unsigned      MAX_RETRY        = 2,
   parameter int unsigned      RDY_LIMIT        = 15
) (
   input  logic               pclk_i,
   input  logic               prst_ni,
   input  logic [1:0]         req_i,
   input  logic [2*WIDTH-1:0] req_data_i,
   input  logic [1:0]         req_verify_i,
   output logic [1:0]         gnt_o,
   output logic [1:0]         done_o,
   output logic [1:0]         err_o,
   output logic               busy_o,
   wdt_cfg_ctrl_if.master     apb
);

   localparam int unsigned      RW        = $clog2(MAX_RETRY + 2);
   localparam int unsigned      WW        = $clog2(RDY_LIMIT + 1);
   localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
   // Last access cycle index (counted from 0) before the wait is abandoned.
   localparam logic [WW-1:0]    WAIT_LAST = WW'(RDY_LIMIT - 1);

   wdt_state_e       state_q,  state_d;
   logic             owner_q,  owner_d;
   logic [WIDTH-1:0] data_q,   data_d;
   logic             verify_q, verify_d;
   logic             err_q,    err_d;
   logic [RW-1:0]    retry_q,  retry_d;
   logic [WW-1:0]    wait_q,   wait_d;

   logic [1:0] arb_gnt;
   logic       arb_accept;
   logic       owner_sel;
   logic       in_setup;
   logic       in_access;

   wdt_rr_arb2 u_arb (
      .clk_i    (pclk_i),
      .rst_ni   (prst_ni),
      .req_i    (req_i),
      .accept_i (arb_accept),
      .gnt_o    (arb_gnt)
   );

   assign owner_sel = arb_gnt[1];

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      data_d     = data_q;
      verify_d   = verify_q;
      err_d      = err_q;
      retry_d    = retry_q;
      wait_d     = wait_q;
      arb_accept = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               arb_accept = 1'b1;
               owner_d    = owner_sel;
               data_d     = owner_sel ? req_data_i[2*WIDTH-1:WIDTH] : req_data_i[WIDTH-1:0];
               verify_d   = req_verify_i[owner_sel];
               err_d      = 1'b0;
               retry_d    = '0;
               wait_d     = '0;
               state_d    = ST_W_SETUP;
            end
         end

         ST_W_SETUP: state_d = ST_W_ACCESS;

         ST_W_ACCESS: begin
            if (apb.pready_i) begin
               wait_d  = '0;
               state_d = verify_q ? ST_R_SETUP : ST_DONE;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         ST_R_SETUP: state_d = ST_R_ACCESS;

         ST_R_ACCESS: begin
            if (apb.pready_i) begin
               wait_d = '0;
               if (apb.prdata_i == data_q) begin
                  state_d = ST_DONE;
               end else if (retry_q < RETRY_MAX) begin
                  // Retry counter only grows while below the limit, so it never wraps.
                  retry_d = retry_q + 1'b1;
                  state_d = ST_W_SETUP;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk_i or negedge prst_ni) begin
      if (!prst_ni) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         data_q   <= '0;
         verify_q <= 1'b0;
         err_q    <= 1'b0;
         retry_q  <= '0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         data_q   <= data_d;
         verify_q <= verify_d;
         err_q    <= err_d;
         retry_q  <= retry_d;
         wait_q   <= wait_d;
      end
   end

   assign in_setup  = (state_q == ST_W_SETUP)  || (state_q == ST_R_SETUP);
   assign in_access = (state_q == ST_W_ACCESS) || (state_q == ST_R_ACCESS);

   // Address and data are parked at zero whenever the bus is not selected.
   assign apb.psel_o    = in_setup || in_access;
   assign apb.penable_o = in_access;
   assign apb.pwrite_o  = (state_q == ST_W_SETUP) || (state_q == ST_W_ACCESS);
   assign apb.paddr_o   = apb.psel_o ? TIMEOUT_REG_ADDR : '0;
   assign apb.pwdata_o  = apb.psel_o ? data_q : '0;

   // The grant is a Mealy pulse in IDLE; reset masks it so every output is low while held.
   assign gnt_o  = ((state_q == ST_IDLE) && prst_ni) ? arb_gnt : 2'b00;
   assign busy_o = (state_q != ST_IDLE);
   assign done_o = (state_q == ST_DONE) ? wdt_onehot(owner_q) : 2'b00;
   assign err_o  = ((state_q == ST_DONE) && err_q) ? wdt_onehot(owner_q) : 2'b00;

endmodule

// File: doc/wdt_cfg_ctrl.md
WDT_CFG_CTRL -- requirements
Module: wdt_cfg_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the APB address/data and timeout value width.
REQ-002 Parameter TIMEOUT_REG_ADDR, default 8'hA0, SHALL be the watchdog timeout register address.
REQ-003 Parameter MAX_RETRY, default 2, SHALL be the number of rewrites allowed after a readback mismatch.
REQ-004 Parameter RDY_LIMIT, default 15, SHALL be the access cycles allowed without pready_i before abort.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be pclk_i (input, 1, rising-edge clock) and prst_ni (input, 1, asynchronous active-low reset).
REQ-006 req_i  input  2  per-requester request, level, held until done_o.
REQ-007 req_data_i  input  2*WIDTH  timeout value; requester n occupies bits [n*WIDTH +: WIDTH].
REQ-008 req_verify_i  input  2  per-requester readback-verify enable.
REQ-009 gnt_o / done_o / err_o  output  2 each  one-cycle one-hot pulses: grant, completion, failure.
REQ-010 busy_o  output  1  high from the cycle after a grant until done_o.
REQ-011 psel_o, penable_o, pwrite_o  output  1 each; paddr_o, pwdata_o  output  WIDTH  APB master controls.
REQ-012 pready_i  input  1; prdata_i  input  WIDTH  APB completer responses.

Function
REQ-013 FSM states SHALL be IDLE, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS, DONE.
REQ-014 In IDLE with any req_i bit set, the block SHALL pulse gnt_o for one requester, latch its data and verify bit, and enter W_SETUP.
REQ-015 Arbitration SHALL be two-way round-robin: on simultaneous requests the requester not granted last wins; after reset requester 0 wins.
REQ-016 W_SETUP SHALL drive psel_o=1, penable_o=0, pwrite_o=1, paddr_o=TIMEOUT_REG_ADDR, pwdata_o=latched value for exactly one cycle.
REQ-017 W_ACCESS SHALL drive psel_o=1, penable_o=1 and hold all APB outputs stable until pready_i=1.
REQ-018 When the write completes, the FSM SHALL enter R_SETUP if verify is set, otherwise DONE.
REQ-019 R_SETUP/R_ACCESS SHALL mirror W_SETUP/W_ACCESS with pwrite_o=0; prdata_i SHALL be sampled in the completing cycle.
REQ-020 A readback matching the latched value SHALL lead to DONE without error; on a mismatch the FSM SHALL return to W_SETUP while retries < MAX_RETRY, otherwise go to DONE with error.
REQ-021 An access phase reaching RDY_LIMIT cycles without pready_i SHALL deassert psel_o/penable_o and go to DONE with error.
REQ-022 DONE SHALL last one cycle, pulse done_o for the granted requester, and pulse err_o in the same cycle for a failed transaction; the next state SHALL be IDLE.
REQ-023 Latency with a completer returning pready_i on the second access cycle SHALL be: grant at T, psel_o at T+1, write done_o at T+4, verified done_o at T+7.
REQ-024 req_i and req_data_i changes while busy SHALL be ignored; a request still held in IDLE SHALL be re-arbitrated.
REQ-025 pready_i outside an access phase SHALL be ignored; psel_o SHALL be 0 in IDLE and DONE.
REQ-026 The retry and ready-wait counters SHALL clear on every grant and every setup entry, and SHALL saturate without wrapping.

Reset
REQ-027 Asserting prst_ni SHALL immediately force state IDLE, all outputs 0, counters 0, and the round-robin pointer to favour requester 0, including mid-transfer.
REQ-028 After prst_ni deasserts, the first grant SHALL occur on the first rising edge with a request present.

Structure
REQ-029 WIDTH, TIMEOUT_REG_ADDR and the FSM state encoding SHALL be defined in the shared package wdt_pkg.
REQ-030 The arbiter SHALL be a sub-module wdt_rr_arb2 with a request vector in, a one-hot grant out, and a pointer update on accept.

Verification
REQ-031 Requester 0 writes 8'h40 with no verify against a WDT-like completer -> APB write to 8'hA0, done_o=2'b01 at T+4, err_o=0.
REQ-032 Both requesters request 8'h10 and 8'h20 in the same cycle -> requester 0 granted first, then requester 1, then requester 0 again if still held.
REQ-033 Verify write of 8'h55 with the completer returning 8'h54 on every read -> 3 writes, then done_o and err_o pulse together.
REQ-034 pready_i held low -> psel_o drops after 15 access cycles; done_o and err_o pulse.
REQ-035 prst_ni pulsed low during W_ACCESS -> APB outputs 0 asynchronously; the held request is re-granted after release with requester 0 priority.
